// File: rtl/lattice_pingpong_bank_if.sv
// lattice_pingpong_bank_if
// Groups the init, read, write and swap signals of the double-buffered
// distribution store so that they can be passed as a single port.
//   master : the solver side (drives init/read/write/swap requests)
//   slave  : the store itself (lattice_pingpong_bank)
// Channel k of any packed multi-channel bus sits at [k*W +: W].
interface lattice_pingpong_bank_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 12,
  parameter int Q             = 9
) ();

  logic                       init_start;
  logic [Q*DATA_WIDTH-1:0]    init_vals;
  logic                       init_busy;
  logic                       init_done;
  logic                       ready;
  logic                       rd_en;
  logic [ADDRESS_WIDTH-1:0]   rd_addr;
  logic                       rd_valid;
  logic [Q*DATA_WIDTH-1:0]    rd_data;
  logic [Q-1:0]               wr_en;
  logic [Q*ADDRESS_WIDTH-1:0] wr_addr;
  logic [Q*DATA_WIDTH-1:0]    wr_data;
  logic                       swap_req;
  logic                       swap_ack;
  logic                       bank_sel;
  logic [31:0]                step_count;
  logic                       err_addr;

  modport master (
    output init_start, init_vals, rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    input  init_busy, init_done, ready, rd_valid, rd_data, swap_ack, bank_sel,
           step_count, err_addr
  );

  modport slave (
    input  init_start, init_vals, rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
    output init_busy, init_done, ready, rd_valid, rd_data, swap_ack, bank_sel,
           step_count, err_addr
  );

endinterface

// File: rtl/lattice_pingpong_bank.sv
// lattice_pingpong_bank
// Double-buffered distribution store for the LBM solver: Q channels, each
// with a "current" and a "next" bank of DEPTH words. Provides a built-in
// fill of both banks, a 1-cycle registered read of the current bank for all
// channels, independent per-channel writes into the next bank, and a swap
// handshake that flips the banks and counts completed steps.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : lattice_pingpong_bank_if.slave (init, read, write, swap, status)
module lattice_pingpong_bank #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int Q             = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  lattice_pingpong_bank_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the range compare also works when DEPTH == 2**ADDRESS_WIDTH.
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, SWAP} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] fill_cnt;
  logic                     bank_sel_q;
  logic [31:0]              step_q;
  logic                     err_q;
  logic                     rd_valid_q;
  logic                     init_done_q;
  logic                     swap_ack_q;

  logic                     ready;
  logic                     fill_last;
  logic                     enter_init;
  logic                     swap_go;
  logic                     rd_fire;
  logic                     rd_in_range;
  logic                     wr_bad;
  logic [Q-1:0]             wr_in_range;
  logic [Q-1:0]             wr_commit;

  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  // Next-state and request decode. init_start wins over swap_req; SWAP is a
  // single fixed cycle that ignores everything and falls back to RUN.
  always_comb begin
    state_next  = state;
    ready       = (state == RUN);
    fill_last   = (state == INIT) && (fill_cnt == LAST_ADDR);
    enter_init  = bus.init_start && (state != SWAP);
    swap_go     = ready && bus.swap_req && !bus.init_start;
    rd_fire     = ready && bus.rd_en;
    rd_in_range = in_range(bus.rd_addr);
    wr_bad      = ready && |(bus.wr_en & ~wr_in_range);
    case (state)
      IDLE: if (bus.init_start) state_next = INIT;
      INIT: begin
        if (bus.init_start)  state_next = INIT;
        else if (fill_last)  state_next = RUN;
      end
      RUN: begin
        if (bus.init_start)    state_next = INIT;
        else if (bus.swap_req) state_next = SWAP;
      end
      SWAP:    state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Control state. The bank flip and step increment land on the same edge
  // that leaves RUN for SWAP, so they are visible together with swap_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      bank_sel_q  <= 1'b0;
      step_q      <= '0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      state       <= state_next;
      init_done_q <= fill_last && !bus.init_start;
      swap_ack_q  <= swap_go;
      rd_valid_q  <= rd_fire;
      if (enter_init)         fill_cnt <= '0;
      else if (state == INIT) fill_cnt <= fill_cnt + ADDRESS_WIDTH'(1);
      if (enter_init) begin
        bank_sel_q <= 1'b0;
        step_q     <= '0;
      end else if (swap_go) begin
        bank_sel_q <= ~bank_sel_q;
        step_q     <= step_q + 32'd1;
      end
      if (enter_init)                                  err_q <= 1'b0;
      else if ((rd_fire && !rd_in_range) || wr_bad)    err_q <= 1'b1;
    end
  end

  assign bus.init_busy  = (state == INIT);
  assign bus.init_done  = init_done_q;
  assign bus.ready      = ready;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.bank_sel   = bank_sel_q;
  assign bus.step_count = step_q;
  assign bus.err_addr   = err_q;

  // Per-channel storage. Each bank sees at most one access per cycle: during
  // INIT both banks take the fill write, in RUN the current bank is only read
  // and the next bank only written.
  for (genvar k = 0; k < Q; k++) begin : g_ch
    logic [DATA_WIDTH-1:0]    mem_a [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_b [DEPTH];
    logic [DATA_WIDTH-1:0]    rd_q;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    ival;

    assign waddr          = bus.wr_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata          = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign ival           = bus.init_vals[k*DATA_WIDTH +: DATA_WIDTH];
    assign wr_in_range[k] = in_range(waddr);
    assign wr_commit[k]   = ready && bus.wr_en[k] && wr_in_range[k];

    // Bank A is the next bank when bank_sel is 1.
    always_ff @(posedge clk) begin
      if (state == INIT)
        mem_a[fill_cnt[IDX_W-1:0]] <= ival;
      else if (wr_commit[k] && bank_sel_q)
        mem_a[waddr[IDX_W-1:0]] <= wdata;
    end

    // Bank B is the next bank when bank_sel is 0.
    always_ff @(posedge clk) begin
      if (state == INIT)
        mem_b[fill_cnt[IDX_W-1:0]] <= ival;
      else if (wr_commit[k] && !bank_sel_q)
        mem_b[waddr[IDX_W-1:0]] <= wdata;
    end

    // Registered read of the current bank; out-of-range sites read as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else if (rd_fire) begin
        if (!rd_in_range)    rd_q <= '0;
        else if (bank_sel_q) rd_q <= mem_b[bus.rd_addr[IDX_W-1:0]];
        else                 rd_q <= mem_a[bus.rd_addr[IDX_W-1:0]];
      end
    end

    assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: doc/lattice_pingpong_bank.md
# lattice_pingpong_bank

Parametrised double-buffered distribution store for the LBM solver: Q channels (one per lattice direction), each with a current and a next bank of DEPTH words. It replaces hand-instantiated per-direction RAM pairs. It adds four things on top of plain storage: a built-in init fill, a registered streaming read of the current bank, per-channel writes into the next bank, and a swap handshake that flips banks and counts completed steps.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one distribution value
- DEPTH, 2500, lattice sites per bank
- ADDRESS_WIDTH, 12, site address width; must satisfy 2^ADDRESS_WIDTH >= DEPTH
- Q, 9, channel count (D2Q9 default)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- init_start  in  1  request fill of both banks with init_vals
- init_vals  in  Q*DATA_WIDTH  fill value per channel; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH]
- init_busy  out  1  high while in INIT
- init_done  out  1  one-cycle pulse when the fill completes
- ready  out  1  high in RUN; rd/wr accepted only when ready
- rd_en  in  1  read all Q channels of the current bank at rd_addr
- rd_addr  in  ADDRESS_WIDTH  read site
- rd_valid  out  1  rd_data valid
- rd_data  out  Q*DATA_WIDTH  registered read data
- wr_en  in  Q  per-channel write enable into the next bank
- wr_addr  in  Q*ADDRESS_WIDTH  per-channel destination site (streamed neighbour)
- wr_data  in  Q*DATA_WIDTH  per-channel write data
- swap_req  in  1  end of step; flip banks
- swap_ack  out  1  one-cycle pulse, the cycle the flip takes effect
- bank_sel  out  1  0: bank A is current, B is next; 1: reversed
- step_count  out  32  completed swaps since the last init
- err_addr  out  1  sticky; set when an out-of-range address is seen

## Operation
- States:
  - IDLE (after reset)
  - INIT
  - RUN
  - SWAP
- IDLE:
  - Ignores rd_en, wr_en and swap_req.
  - init_start moves to INIT.
- INIT:
  - A fill counter runs 0..DEPTH-1, one site per cycle.
  - At counter address a, every channel k writes init_vals[k] into both banks.
  - init_vals is sampled every cycle, so it must be held stable by the driver.
  - After address DEPTH-1 the block moves to RUN and pulses init_done.
- Entering INIT clears:
  - bank_sel to 0
  - step_count to 0
  - err_addr to 0
- RUN:
  - rd_en reads bank_sel's current bank at rd_addr for all Q channels.
  - Each channel k with wr_en[k] writes wr_data[k] to the next bank at wr_addr[k]. Channels are independent.
  - swap_req moves to SWAP. Writes presented in that same cycle still commit to the pre-swap next bank.
  - init_start moves to INIT. It has priority over swap_req; no swap_ack is issued.
- SWAP (exactly one cycle):
  - bank_sel toggles, step_count increments with 32-bit wrap, swap_ack pulses.
  - rd_en and wr_en are ignored (ready=0).
  - Returns to RUN.
- Address range:
  - A read at addr >= DEPTH returns all-zero rd_data, with rd_valid still asserted.
  - A write at addr >= DEPTH is dropped for that channel only.
  - Either case sets err_addr.
- A write and a read to the same site in the same cycle never conflict, because they target different banks.
- Storage is 2*Q inferred single-port-per-bank arrays, with no initial contents assumed.

## Timing
- Reset values:
  - state IDLE
  - init_busy=0, init_done=0, ready=0
  - rd_valid=0, rd_data=0
  - swap_ack=0, bank_sel=0, step_count=0, err_addr=0
- rst mid-INIT or mid-SWAP:
  - Returns to IDLE immediately.
  - Memory contents are undefined until the next init.
- Init sequence:
  - init_start sampled in cycle 0.
  - init_busy=1 in cycles 1..DEPTH, writing addresses 0..DEPTH-1.
  - Cycle DEPTH+1: init_done=1, ready=1, init_busy=0.
- Read latency is 1 cycle:
  - rd_en at cycle t gives rd_valid=1 and rd_data at t+1.
  - rd_valid is 0 otherwise; rd_data holds its last value.
  - A read accepted in the swap_req cycle returns pre-flip current-bank data.
- Write latency:
  - A write at cycle t is readable only after the next swap completes, as the current bank.
- Swap timing:
  - swap_req sampled at t gives swap_ack, the bank_sel change and the step_count increment at t+1.
  - ready is 0 at t+1 and 1 at t+2.
  - swap_req is level-sampled: holding it high produces a swap every other cycle.
- init_start during INIT restarts the fill at address 0.

## Test plan
- Fill, then read back: DEPTH=16, init_vals channel k = 0x0100+k; read addresses 0..15 -> every rd_data channel k = 0x0100+k; init_done exactly at cycle 17.
- Ping-pong: after init, write 0x7FFF to channel 3 at addr 5, then swap_req, then read addr 5 -> ch3 = 0x7FFF, other channels = init value; swap_ack=1, bank_sel=1, step_count=1.
- Per-channel scatter: in one cycle ch1 writes addr 2 = 0x1111 and ch5 writes addr 9 = 0x5555; swap, then read addr 2 and addr 9 -> only those two words changed.
- Priority and range: swap_req and init_start asserted together -> no swap_ack, init_busy next cycle; separately, rd_addr=20 with DEPTH=16 -> rd_data=0, rd_valid=1, err_addr stays 1 until the next init.
- Swap stall: wr_en asserted in the SWAP cycle -> data is not stored; write presented in the swap_req cycle -> data visible after that swap.
- Reset mid-init: rst at INIT address 7 -> all outputs at reset values the next cycle; a new init completes normally.
